seq_logic_cmp: RTL and testbench
================================

# seq_logic_cmp

Parametrised multi-cycle bitwise-logic and magnitude-compare unit. It processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, under a start/done handshake. It supports signed and unsigned compares plus equality, which the 32-bit combinational gate library lacks. It sits beside the ALU datapath as a shared, area-lean logic/compare engine.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.
- clk  input  1  rising-edge clock; the design's only clock.
- reset_n  input  1  synchronous, active-low reset.
- op_start  input  1  request; sampled only when not busy.
- op_code  input  4  operation select; latched with the operands.
- a  input  WIDTH  operand A; latched on accept.
- b  input  WIDTH  operand B; latched on accept.
- result  output  WIDTH  registered result; holds until the next completion.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- busy  output  1  high while in RUN.

## Operation
- Opcodes:
  - 0 NOT a
  - 1 AND
  - 2 OR
  - 3 XOR
  - 4 XNOR
  - 5 LTU (unsigned a<b)
  - 6 GTU (unsigned a>b)
  - 7 LTS (signed a<b)
  - 8 GTS (signed a>b)
  - 9 EQ (a==b)
  - 10–15: result = 0. Timing is the same as for every other opcode.
- Compare results are 1 or 0, zero-extended to WIDTH.
- FSM states are IDLE, RUN and DONE.
  - IDLE: when op_start=1, latch a, b and op_code, set cnt=0, clear the flags (lt=0, gt=0, eq=1), go to RUN.
  - RUN: process chunk cnt (bits cnt*CHUNK+CHUNK-1 .. cnt*CHUNK) and increment cnt. When cnt==N-1, copy the accumulator to result, set done=1 and go to DONE.
  - DONE: done=1 for this cycle only. If op_start=1, accept a new operation exactly as in IDLE and go to RUN. Otherwise go to IDLE.
- Bitwise ops: the chunk result is written into the matching slice of the internal accumulator.
- Compare ops: for each chunk, if a_chunk != b_chunk, set lt = (a_chunk < b_chunk) and gt = !lt. Higher chunks override lower ones. eq &= (a_chunk == b_chunk).
- Signed compares: on the top chunk (cnt==N-1), invert the MSB of both chunks before comparing.
- op_start while busy=1 is ignored. No queueing, and the latched operands are unaffected.
- Input changes to a, b or op_code after accept have no effect on the operation in flight.

## Timing
- Reset values when reset_n=0 at a rising edge:
  - state = IDLE
  - result = 0
  - done = 0
  - busy = 0
  - cnt = 0
  - flags cleared
- Reset overrides everything, including mid-RUN. An aborted operation never asserts done and leaves result at 0.
- Latency, with accept at edge E0:
  - chunks are processed at edges E1..EN
  - result and done are registered at EN
  - done falls at E(N+1)
- busy is high from E0 to EN, and low after EN.
- Back-to-back operation: op_start held high in the done cycle is accepted at E(N+1). Sustained throughput is one operation per N+1 cycles.
- The N=1 case (CHUNK=WIDTH) is legal: accept at E0, done registered at E1.
- result changes only at completion edges or reset. It is never partially updated while busy.

## Test plan
- WIDTH=32, CHUNK=8. Reset, then AND with a=0xF0F0_1234, b=0x0FF0_FF00 -> result=0x00F0_1200. Accept at E0, done=1 exactly after E4, busy=1 from E0 to E4.
- LTU with a=0x8000_0000, b=0x0000_0001 -> 0. LTS with the same operands -> 1. GTS with the same operands -> 0.
- Difference only in the lowest chunk: GTU with a=0x1234_5679, b=0x1234_5678 -> 1. EQ with a=b=0xDEAD_BEEF -> 1. EQ with a=0xDEAD_BEEF, b=0xDEAD_BEEE -> 0.
- Busy and hold behaviour:
  - Pulse op_start with XOR 0xFFFF_0000 ^ 0x0F0F_0F0F while RUN -> ignored. The first operation completes unchanged.
  - Opcode 12 -> result=0 with the normal 4-cycle latency.
  - Back-to-back NOT a=0 then OR, with op_start held high -> second op accepted in the done cycle, result=0xFFFF_FFFF and then the OR value.
- Assert reset_n=0 at E2 of a running operation -> done never pulses, result=0, busy=0. An op_start at the next edge is accepted normally.
- WIDTH=8, CHUNK=1 (N=8):
  - XNOR a=0xA5, b=0x0F -> 0x55, done after E8.
  - LTS a=0xFF (−1), b=0x00 -> 1.

Source files
------------

// File: rtl/seq_logic_cmp.sv
// Multi-cycle bitwise-logic / magnitude-compare engine: walks WIDTH-bit operands
// CHUNK bits per clock, LSB chunk first, under a start/done handshake.
module seq_logic_cmp #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, acc;
    logic [3:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             lt, gt, eq;

    int               base;
    logic             last, sgn;
    logic [CHUNK-1:0] a_c, b_c, a_m, b_m, bit_c;
    logic             nlt, ngt, neq;
    logic [WIDTH-1:0] acc_n, res_n;

    always_comb begin
        base  = int'(cnt) * CHUNK;
        last  = (cnt == CW'(N - 1));
        sgn   = (op_q == 4'd7) || (op_q == 4'd8);
        a_c   = a_q[base +: CHUNK];
        b_c   = b_q[base +: CHUNK];
        a_m   = a_c;
        b_m   = b_c;
        // Flipping the sign bit on the top chunk turns a signed compare into unsigned.
        if (sgn && last) begin
            a_m[CHUNK-1] = ~a_c[CHUNK-1];
            b_m[CHUNK-1] = ~b_c[CHUNK-1];
        end
        case (op_q)
            4'd0:    bit_c = ~a_c;
            4'd1:    bit_c = a_c & b_c;
            4'd2:    bit_c = a_c | b_c;
            4'd3:    bit_c = a_c ^ b_c;
            4'd4:    bit_c = ~(a_c ^ b_c);
            default: bit_c = '0;
        endcase
        acc_n = acc;
        acc_n[base +: CHUNK] = bit_c;
        nlt = lt;
        ngt = gt;
        if (a_m != b_m) begin
            nlt = (a_m < b_m);
            ngt = !(a_m < b_m);
        end
        neq = eq & (a_c == b_c);
        case (op_q)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: res_n = acc_n;
            4'd5, 4'd7:                   res_n = WIDTH'(nlt);
            4'd6, 4'd8:                   res_n = WIDTH'(ngt);
            4'd9:                         res_n = WIDTH'(neq);
            default:                      res_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
            lt     <= 1'b0;
            gt     <= 1'b0;
            eq     <= 1'b1;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (op_start) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op_code;
                        cnt   <= '0;
                        lt    <= 1'b0;
                        gt    <= 1'b0;
                        eq    <= 1'b1;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    lt  <= nlt;
                    gt  <= ngt;
                    eq  <= neq;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        result <= res_n;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_logic_cmp.sv
// Bench for seq_logic_cmp: 32/8 and 8/1 instances, scoreboard queues popped on done.
module tb_seq_logic_cmp;
    logic        clk = 1'b0;
    logic        rst32, start32, done32, busy32;
    logic [3:0]  code32;
    logic [31:0] a32, b32, res32;
    logic        rst8, start8, done8, busy8;
    logic [3:0]  code8;
    logic [7:0]  a8, b8, res8;

    int checks = 0;
    int errors = 0;
    logic [31:0] q32[$];
    logic [7:0]  q8[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] av;
        logic [31:0] bv;
        logic [31:0] ex;
        bit          poke;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    seq_logic_cmp #(.WIDTH(32), .CHUNK(8)) dut32 (
        .clk(clk), .reset_n(rst32), .op_start(start32), .op_code(code32),
        .a(a32), .b(b32), .result(res32), .done(done32), .busy(busy32));

    seq_logic_cmp #(.WIDTH(8), .CHUNK(1)) dut8 (
        .clk(clk), .reset_n(rst8), .op_start(start8), .op_code(code8),
        .a(a8), .b(b8), .result(res8), .done(done8), .busy(busy8));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done32 result=%h", res32);
            end else begin
                chk("result32", res32, q32.pop_front());
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done8 result=%h", res8);
            end else begin
                chk("result8", {24'd0, res8}, {24'd0, q8.pop_front()});
            end
        end
    end

    // Issue one 32-bit op; optionally pokes a conflicting request while busy.
    task automatic run32(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] ex, input bit poke);
        int k;
        @(negedge clk);
        start32 = 1'b1; code32 = op; a32 = av; b32 = bv;
        q32.push_back(ex);
        @(posedge clk); #1 start32 = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk); k++;
            if (k == 1) chk("busy_after_accept", {31'd0, busy32}, 32'd1);
            if (poke && k == 2) begin
                start32 = 1'b1; code32 = 4'd3; a32 = 32'hFFFF_0000; b32 = 32'h0F0F_0F0F;
            end
            if (poke && k == 3) start32 = 1'b0;
            if (done32) break;
        end
        chk("latency32", k, 32'd5);
        chk("busy_at_done", {31'd0, busy32}, 32'd0);
    endtask

    task automatic run8(input logic [3:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ex);
        int k;
        @(negedge clk);
        start8 = 1'b1; code8 = op; a8 = av; b8 = bv;
        q8.push_back(ex);
        @(posedge clk); #1 start8 = 1'b0;
        k = 0;
        while (k < 30) begin
            @(negedge clk); k++;
            if (done8) break;
        end
        chk("latency8", k, 32'd9);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        tbl.push_back('{4'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0});
        tbl.push_back('{4'd5, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0});
        tbl.push_back('{4'd7, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0});
        tbl.push_back('{4'd8, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0});
        tbl.push_back('{4'd6, 32'h1234_5679, 32'h1234_5678, 32'h0000_0001, 1'b0});
        tbl.push_back('{4'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001, 1'b0});
        tbl.push_back('{4'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEE, 32'h0000_0000, 1'b0});
        tbl.push_back('{4'd1, 32'h1234_5678, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1});
        tbl.push_back('{4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0});
        tbl.push_back('{4'd3, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0});
        tbl.push_back('{4'd4, 32'h0000_FFFF, 32'h00FF_00FF, 32'hFF00_00FF, 1'b0});
        tbl.push_back('{4'd5, 32'h0000_0001, 32'h8000_0000, 32'h0000_0001, 1'b0});

        rst32 = 1'b0; start32 = 1'b0; code32 = '0; a32 = '0; b32 = '0;
        rst8  = 1'b0; start8  = 1'b0; code8  = '0; a8  = '0; b8  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_result32", res32, 32'd0);
        chk("rst_done32", {31'd0, done32}, 32'd0);
        chk("rst_busy32", {31'd0, busy32}, 32'd0);
        chk("rst_result8", {24'd0, res8}, 32'd0);
        rst32 = 1'b1; rst8 = 1'b1;

        foreach (tbl[i]) run32(tbl[i].op, tbl[i].av, tbl[i].bv, tbl[i].ex, tbl[i].poke);

        // Back-to-back: start held through the done cycle; inputs switched to OR mid-run.
        @(negedge clk);
        start32 = 1'b1; code32 = 4'd0; a32 = 32'h0; b32 = 32'h0;
        q32.push_back(32'hFFFF_FFFF);
        @(posedge clk); #1;
        code32 = 4'd2; a32 = 32'h1200_0034; b32 = 32'h0034_5600;
        q32.push_back(32'h1234_5634);
        k = 0;
        while (k < 20) begin @(negedge clk); k++; if (done32) break; end
        chk("b2b_first_latency", k, 32'd5);
        @(posedge clk); #1 start32 = 1'b0;
        k = 0;
        while (k < 20) begin
            @(negedge clk); k++;
            if (k == 1) chk("b2b_busy", {31'd0, busy32}, 32'd1);
            if (done32) break;
        end
        chk("b2b_second_latency", k, 32'd5);

        // Reset lands at E2 of an AND in flight: no done, result cleared.
        @(negedge clk);
        start32 = 1'b1; code32 = 4'd1; a32 = 32'hFFFF_FFFF; b32 = 32'hFFFF_FFFF;
        @(posedge clk); #1 start32 = 1'b0;
        @(negedge clk);
        @(negedge clk); rst32 = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy32}, 32'd0);
        chk("abort_done", {31'd0, done32}, 32'd0);
        chk("abort_result", res32, 32'd0);
        rst32 = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_result_hold", res32, 32'd0);
        run32(4'd2, 32'hA000_0000, 32'h0000_000B, 32'hA000_000B, 1'b0);

        run8(4'd4, 8'hA5, 8'h0F, 8'h55);
        run8(4'd7, 8'hFF, 8'h00, 8'h01);
        run8(4'd8, 8'hFF, 8'h00, 8'h00);
        run8(4'd6, 8'h80, 8'h7F, 8'h01);

        repeat (3) @(negedge clk);
        checks++;
        if (q32.size() != 0 || q8.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain q32=%0d q8=%0d", q32.size(), q8.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
